// File: rtl/wimpfi_pkg.sv
// Shared types and constants for the WimpFi link controller slice.
// The link state encoding is visible on the link_state port.
package wimpfi_pkg;

    typedef enum logic [1:0] {
        LINK_IDLE  = 2'd0,
        LINK_RX    = 2'd1,
        LINK_TX    = 2'd2,
        LINK_GUARD = 2'd3
    } link_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/wimpfi_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// A synchronous clear takes priority over a same-cycle increment.
module wimpfi_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/wimpfi_link_controller.sv
// Half-duplex medium-access controller between the WimpFi cores and the radio pins:
// link FSM, pin gating, echo blanking, loopback, carrier sense and error/collision counters.
module wimpfi_link_controller
    import wimpfi_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BIT_RATE   = 50_000,
    parameter int GUARD_BITS = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_txd,
    input  logic             core_tx_en,
    input  logic             rxd,
    input  logic             rcvr_cardet,
    input  logic             forced_cardet,
    input  logic             loopback,
    input  logic             xerr_pulse,
    input  logic             rerr_pulse,
    input  logic             clr_cnt,
    output logic             txd,
    output logic             tx_en,
    output logic             core_rxd,
    output logic             cardet_out,
    output logic [1:0]       link_state,
    output logic [ERR_W-1:0] xerrcnt,
    output logic [ERR_W-1:0] rerrcnt,
    output logic [ERR_W-1:0] collcnt
);

    localparam int DIV = CLK_FREQ / BIT_RATE;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW  = $clog2(GUARD_BITS + 1);

    link_state_t   state_q, state_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [DW-1:0] div_q;
    logic          tick;
    logic          rxd_meta_q, rxd_s_q;
    logic          txd_q, tx_en_q, core_rxd_q;
    logic          coll_inc;

    // Free-running bit-time divider; its phase is never realigned to TX end,
    // so the first guard tick may arrive early by up to one bit time.
    assign tick = (div_q == DW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // A TX request always wins; coming out of RX it is still granted but counted as a collision.
    always_comb begin
        state_d  = state_q;
        guard_d  = guard_q;
        coll_inc = 1'b0;
        unique case (state_q)
            LINK_IDLE: begin
                if (core_tx_en) begin
                    state_d = LINK_TX;
                end else if (rcvr_cardet) begin
                    state_d = LINK_RX;
                end
            end
            LINK_RX: begin
                if (core_tx_en) begin
                    state_d  = LINK_TX;
                    coll_inc = 1'b1;
                end else if (!rcvr_cardet) begin
                    state_d = LINK_IDLE;
                end
            end
            LINK_TX: begin
                if (!core_tx_en) begin
                    state_d = LINK_GUARD;
                    guard_d = GW'(GUARD_BITS);
                end
            end
            LINK_GUARD: begin
                if (core_tx_en) begin
                    state_d = LINK_TX;
                end else if (tick) begin
                    guard_d = guard_q - GW'(1);
                    if (guard_q <= GW'(1)) begin
                        state_d = LINK_IDLE;
                    end
                end
            end
            default: state_d = LINK_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LINK_IDLE;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
        end
    end

    // Pins follow the next state so TX data leaves exactly one clock after the core drives it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txd_q      <= TX_IDLE_LEVEL;
            tx_en_q    <= 1'b0;
            core_rxd_q <= 1'b1;
        end else begin
            txd_q      <= (state_d == LINK_TX) ? core_txd : TX_IDLE_LEVEL;
            tx_en_q    <= (state_d == LINK_TX) && !loopback;
            if (loopback) begin
                core_rxd_q <= txd_q;
            end else if ((state_q == LINK_TX) || (state_q == LINK_GUARD)) begin
                core_rxd_q <= 1'b1;
            end else begin
                core_rxd_q <= rxd_s_q;
            end
        end
    end

    assign txd        = txd_q;
    assign tx_en      = tx_en_q;
    assign core_rxd   = core_rxd_q;
    assign cardet_out = rcvr_cardet | forced_cardet;
    assign link_state = state_q;

    wimpfi_sat_counter #(.W(ERR_W)) u_xerr (
        .clk   (clk),
        .rst_n (rst),
        .inc   (xerr_pulse),
        .clr   (clr_cnt),
        .q     (xerrcnt)
    );

    wimpfi_sat_counter #(.W(ERR_W)) u_rerr (
        .clk   (clk),
        .rst_n (rst),
        .inc   (rerr_pulse),
        .clr   (clr_cnt),
        .q     (rerrcnt)
    );

    wimpfi_sat_counter #(.W(ERR_W)) u_coll (
        .clk   (clk),
        .rst_n (rst),
        .inc   (coll_inc),
        .clr   (clr_cnt),
        .q     (collcnt)
    );

endmodule
